// File: rtl/sbus_frame_tx.sv
// SBUS frame transmitter: 16 x 11-bit channels plus flags sent as a periodic 25-byte 8E2 frame.
// Optional macro SBUS_INVERT_EN selects native inverted wire polarity (idle wire low).
module sbus_frame_tx #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned BAUD            = 100_000,
    parameter int unsigned FRAME_PERIOD_US = 14000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [175:0] ch_data,
    input  logic [3:0]   flags_in,
    output logic         tx_out,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned BIT_DIV    = CLK_HZ / BAUD;
    localparam int unsigned PERIOD_CYC = CLK_HZ / 1_000_000 * FRAME_PERIOD_US;
    localparam int          CNT_W      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int          TMR_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CYC - 1);

`ifdef SBUS_INVERT_EN
    localparam logic WIRE_INV = 1'b1;
`else
    localparam logic WIRE_INV = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [4:0]       byte_idx, byte_idx_nxt;
    logic [199:0]     frame_reg;
    logic [7:0]       cur_byte;
    logic [TMR_W-1:0] timer;
    logic             en_q, pending, line_nxt;
    logic             bit_end, last_bit, byte_end, period_hit, true_wrap, start_now;

    assign bit_end    = (bit_cnt == BIT_LAST);
    assign byte_end   = (state == S_STOP2) && bit_end;
    assign last_bit   = byte_end && (byte_idx == 5'd24);
    assign period_hit = en && (timer == '0);
    // en_q separates a real wrap from the timer merely sitting at 0 after en rises
    assign true_wrap  = period_hit && en_q;
    assign start_now  = ((state == S_IDLE) && period_hit) ||
                        (last_bit && en && (pending || true_wrap));
    assign busy       = (state != S_IDLE);
    assign frame_done = last_bit;
    assign cur_byte   = frame_reg[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q <= en;
            if (!en || timer == TMR_LAST) timer <= '0;
            else                          timer <= timer + 1'b1;
        end
    end

    // A wrap that lands mid-frame is remembered and served right after frame_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           pending <= 1'b0;
        else if (!en || start_now || !busy) pending <= 1'b0;
        else if (true_wrap)                 pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          frame_reg <= '0;
        else if (start_now) frame_reg <= {8'h00, 4'h0, flags_in, ch_data, 8'h0F};
        else if (byte_end)  frame_reg <= {8'h00, frame_reg[199:8]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_out   <= ~WIRE_INV;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            tx_out   <= line_nxt ^ WIRE_INV;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_end ? '0 : bit_cnt + 1'b1;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        case (state)
            S_IDLE: begin
                bit_cnt_nxt = '0;
                if (start_now) begin
                    state_nxt    = S_START;
                    byte_idx_nxt = 5'd0;
                end
            end
            S_START: if (bit_end) begin
                state_nxt   = S_DATA;
                bit_idx_nxt = 3'd0;
            end
            S_DATA: if (bit_end) begin
                if (bit_idx == 3'd7) state_nxt   = S_PARITY;
                else                 bit_idx_nxt = bit_idx + 3'd1;
            end
            S_PARITY: if (bit_end) state_nxt = S_STOP1;
            S_STOP1:  if (bit_end) state_nxt = S_STOP2;
            S_STOP2: if (bit_end) begin
                if (byte_idx != 5'd24) begin
                    state_nxt    = S_START;
                    byte_idx_nxt = byte_idx + 5'd1;
                end else if (start_now) begin
                    state_nxt    = S_START;
                    byte_idx_nxt = 5'd0;
                end else begin
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The line level follows the next state so tx_out is a pure register
    always_comb begin
        line_nxt = 1'b1;
        case (state_nxt)
            S_START:  line_nxt = 1'b0;
            S_DATA:   line_nxt = cur_byte[bit_idx_nxt];
            S_PARITY: line_nxt = ^cur_byte;
            default:  line_nxt = 1'b1;
        endcase
    end

endmodule
